// File: rtl/div_unit_seq.sv
// Iterative radix-2 restoring divide/remainder unit for DIV, DIVU, REM, REMU.
// One quotient bit per clock. START/BUSY/DONE handshake; RESULT is held
// until the next completion.
module div_unit_seq #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [1:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;     // partial remainder
  logic [XLEN-1:0]   quo_q, quo_d;     // dividend shifting out / quotient shifting in
  logic [XLEN-1:0]   dvs_q, dvs_d;     // |divisor|
  logic [1:0]        sel_q, sel_d;
  logic              nq_q, nq_d;       // negate quotient at the end
  logic              nr_q, nr_d;       // negate remainder at the end
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Working values shared by the accept and iterate paths
  logic              is_signed;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     shifted;          // 33-bit partial remainder after shift
  logic              fits;
  logic [XLEN-1:0]   q_fix, r_fix;

  assign is_signed = ~SELECT[0];
  assign a_abs     = (is_signed && DATA1[XLEN-1]) ? ('0 - DATA1) : DATA1;
  assign b_abs     = (is_signed && DATA2[XLEN-1]) ? ('0 - DATA2) : DATA2;
  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign fits      = (shifted >= {1'b0, dvs_q});
  assign q_fix     = nq_q ? ('0 - quo_q) : quo_q;
  assign r_fix     = nr_q ? ('0 - rem_q) : rem_q;

  // Next-state and datapath for the IDLE/RUN/FIX/ZERO sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sel_d    = sel_q;
    nq_d     = nq_q;
    nr_d     = nr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          sel_d  = SELECT;
          nq_d   = is_signed & (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
          nr_d   = is_signed & DATA1[XLEN-1];
          rem_d  = '0;
          dvs_d  = b_abs;
          busy_d = 1'b1;
          if (DATA2 == '0) begin
            // raw dividend kept so REM/REMU by zero return it untouched
            quo_d   = DATA1;
            state_d = ZERO;
          end else begin
            quo_d   = a_abs;
            cnt_d   = CW'(XLEN - 1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (fits) begin
          rem_d = XLEN'(shifted - {1'b0, dvs_q});
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        result_d = sel_q[1] ? r_fix : q_fix;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      ZERO: begin
        result_d = sel_q[1] ? quo_q : '1;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; async reset aborts any in-flight op
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sel_q    <= '0;
      nq_q     <= 1'b0;
      nr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sel_q    <= sel_d;
      nq_q     <= nq_d;
      nr_q     <= nr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_div_unit_seq.sv
// Directed bench for div_unit_seq: latency, signed/unsigned results,
// divide-by-zero, overflow, handshake and mid-operation reset.
module tb_div_unit_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [1:0]  SELECT;
  logic [31:0] DATA1, DATA2;
  logic        BUSY, DONE;
  logic [31:0] RESULT;

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  div_unit_seq #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One full operation from START through DONE and one cycle after
  task automatic run_op(input string tag, input logic [1:0] sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int lat;
    int bad;
    lat = (b == 32'd0) ? 1 : 33;
    bad = 0;
    @(negedge CLK);
    START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    @(posedge CLK); #1;
    START = 1'b0; DATA1 = $urandom; DATA2 = $urandom; SELECT = 2'($urandom);
    chk({tag, ":busy_at_accept"}, {31'd0, BUSY}, 32'd1);
    for (int e = 1; e < lat; e++) begin
      @(posedge CLK); #1;
      if (DONE !== 1'b0 || BUSY !== 1'b1) bad++;
    end
    chk({tag, ":busy_wait"}, bad, 32'd0);
    @(posedge CLK); #1;
    chk({tag, ":done"},   {31'd0, DONE}, 32'd1);
    chk({tag, ":busy_lo"}, {31'd0, BUSY}, 32'd0);
    chk({tag, ":result"}, RESULT, exp);
    @(posedge CLK); #1;
    chk({tag, ":done_pulse"}, {31'd0, DONE}, 32'd0);
    chk({tag, ":held"}, RESULT, exp);
  endtask

  initial begin
    int bad;
    int seen;
    RESET = 1'b0; START = 1'b0; SELECT = 2'd0; DATA1 = '0; DATA2 = '0;
    #12;
    chk("reset_busy",   {31'd0, BUSY}, 32'd0);
    chk("reset_done",   {31'd0, DONE}, 32'd0);
    chk("reset_result", RESULT, 32'd0);
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK);

    // Basic unsigned and signed
    run_op("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14);
    run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2);
    run_op("div_m7_2",   2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_m7_2",   2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("div_7_m2",   2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_op("rem_7_m2",   2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1);
    run_op("divu_max_1", 2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run_op("remu_max_64k", 2'd3, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF);
    run_op("divu_5_max", 2'd1, 32'd5, 32'hFFFF_FFFF, 32'd0);

    // Divide by zero
    run_op("div_5_0",    2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("divu_5_0",   2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("rem_5_0",    2'd2, 32'd5, 32'd0, 32'd5);
    run_op("remu_5_0",   2'd3, 32'd5, 32'd0, 32'd5);
    run_op("rem_m7_0",   2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

    // Signed overflow corner
    run_op("div_ovf",  2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",  2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("divu_ovf", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("remu_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

    // Handshake: re-pulsed START while busy is ignored
    @(negedge CLK);
    START = 1'b1; SELECT = 2'd1; DATA1 = 32'd1000; DATA2 = 32'd10;
    @(posedge CLK); #1;
    START = 1'b0;
    bad = 0;
    for (int e = 1; e <= 32; e++) begin
      START  = (e == 5 || e == 20);
      DATA1  = 32'(e * 3);
      DATA2  = (e == 20) ? 32'd0 : 32'd7;
      SELECT = 2'(e);
      @(posedge CLK); #1;
      if (DONE !== 1'b0 || BUSY !== 1'b1) bad++;
    end
    chk("hs:busy_wait", bad, 32'd0);
    // START held across the DONE edge (ignored) and the next one (accepted)
    START = 1'b1; SELECT = 2'd1; DATA1 = 32'd9; DATA2 = 32'd3;
    @(posedge CLK); #1;
    chk("hs:done",   {31'd0, DONE}, 32'd1);
    chk("hs:busy_lo", {31'd0, BUSY}, 32'd0);
    chk("hs:result", RESULT, 32'd100);
    @(posedge CLK); #1;
    START = 1'b0;
    chk("hs:reaccept_busy", {31'd0, BUSY}, 32'd1);
    chk("hs:reaccept_done", {31'd0, DONE}, 32'd0);
    chk("hs:old_result",    RESULT, 32'd100);
    bad = 0;
    for (int e = 1; e < 33; e++) begin
      @(posedge CLK); #1;
      if (DONE !== 1'b0 || BUSY !== 1'b1) bad++;
    end
    chk("hs2:busy_wait", bad, 32'd0);
    @(posedge CLK); #1;
    chk("hs2:done",   {31'd0, DONE}, 32'd1);
    chk("hs2:result", RESULT, 32'd3);

    // Reset in the middle of RUN
    @(negedge CLK);
    START = 1'b1; SELECT = 2'd1; DATA1 = 32'd1000; DATA2 = 32'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("rst_mid:busy",   {31'd0, BUSY}, 32'd0);
    chk("rst_mid:done",   {31'd0, DONE}, 32'd0);
    chk("rst_mid:result", RESULT, 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK); RESET = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE !== 1'b0 || BUSY !== 1'b0) seen++;
    end
    chk("rst_mid:no_done", seen, 32'd0);
    run_op("post_rst_divu_9_3", 2'd1, 32'd9, 32'd3, 32'd3);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
